// File: rtl/ctrl_pipe_chain_pkg.sv
// Shared definitions for the control-bundle pipeline chain: control field
// layout, the all-zero NOP bundle and the per-cycle action encoding.
package ctrl_pipe_chain_pkg;

  localparam int unsigned DEF_REG_W      = 4;

  // Control bundle field layout (LSB offsets and widths)
  localparam int unsigned CTRL_AM_LSB     = 0;
  localparam int unsigned CTRL_AM_W       = 2;
  localparam int unsigned CTRL_ALU_OP_LSB = 2;
  localparam int unsigned CTRL_ALU_OP_W   = 4;
  localparam int unsigned CTRL_RF_EN      = 6;
  localparam int unsigned CTRL_S          = 7;
  localparam int unsigned CTRL_DATAMEM_EN = 8;
  localparam int unsigned CTRL_RW         = 9;
  localparam int unsigned CTRL_SIZE_LSB   = 10;
  localparam int unsigned CTRL_SIZE_W     = 2;
  localparam int unsigned CTRL_LOAD       = 12;
  localparam int unsigned CTRL_BL         = 13;

  localparam logic [15:0] CTRL_NOP        = '0;

  // What the chain does this cycle, highest priority first: hold, flush, hazard, shift
  typedef enum logic [1:0] {
    ACT_SHIFT  = 2'd0,
    ACT_HAZARD = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_HOLD   = 2'd3
  } pipe_act_e;

endpackage

// File: rtl/ctrl_pipe_chain_stage_reg.sv
// One pipeline stage register for the control chain. Holds on hold, loads a
// bubble (all zeros) on bubble, otherwise captures d_*.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              bubble,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [REG_W-1:0]  d_rd,
  input  logic              d_is_load,
  input  logic              d_rd_we,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [REG_W-1:0]  q_rd,
  output logic              q_is_load,
  output logic              q_rd_we
);

  // Stage contents: async clear, then hold > bubble > capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid   <= 1'b0;
      q_ctrl    <= '0;
      q_rd      <= '0;
      q_is_load <= 1'b0;
      q_rd_we   <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        q_valid   <= 1'b0;
        q_ctrl    <= '0;
        q_rd      <= '0;
        q_is_load <= 1'b0;
        q_rd_we   <= 1'b0;
      end else begin
        q_valid   <= d_valid;
        q_ctrl    <= d_ctrl;
        q_rd      <= d_rd;
        q_is_load <= d_is_load;
        q_rd_we   <= d_rd_we;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control-bundle pipeline chain from ID through STAGES stages (stage 0 = EX)
// with load-use hazard bubbling, branch flush, external stall and counters.
module ctrl_pipe_chain
  import ctrl_pipe_chain_pkg::*;
#(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned STAGES = 3,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [CTRL_W-1:0]        id_ctrl,
  input  logic                     id_is_load,
  input  logic                     id_rd_we,
  input  logic [REG_W-1:0]         id_rd,
  input  logic [REG_W-1:0]         id_rs_a,
  input  logic [REG_W-1:0]         id_rs_b,
  input  logic                     id_rs_a_use,
  input  logic                     id_rs_b_use,
  input  logic                     flush,
  input  logic                     ext_stall,
  output logic                     pc_le,
  output logic                     ifid_le,
  output logic                     ifid_clr,
  output logic                     hazard,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [STAGES*REG_W-1:0]  stage_rd,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] we;
  logic [CTRL_W-1:0] c [STAGES];
  logic [REG_W-1:0]  r [STAGES];
  pipe_act_e         act;
  logic              unused_tail;

  // Load-use hazard against the instruction currently in EX
  always_comb begin
    hazard = v[0] & ld[0] & we[0] & id_valid &
             ((id_rs_a_use & (id_rs_a == r[0])) | (id_rs_b_use & (id_rs_b == r[0])));
  end

  // Per-cycle action selection
  always_comb begin
    act = ACT_SHIFT;
    if (ext_stall)   act = ACT_HOLD;
    else if (flush)  act = ACT_FLUSH;
    else if (hazard) act = ACT_HAZARD;
  end

  // Front-end enables; forced to run/no-clear while reset is asserted
  always_comb begin
    pc_le    = 1'b1;
    ifid_le  = 1'b1;
    ifid_clr = 1'b0;
    if (reset) begin
      unique case (act)
        ACT_HOLD:   begin pc_le = 1'b0; ifid_le = 1'b0; end
        ACT_FLUSH:  ifid_clr = 1'b1;
        ACT_HAZARD: begin pc_le = 1'b0; ifid_le = 1'b0; end
        default:    ;
      endcase
    end
  end

  // Stage 0 takes the ID bundle; later stages take their predecessor
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      pipe_stage_reg #(.CTRL_W(CTRL_W), .REG_W(REG_W)) u_reg (
        .clk       (clk),
        .rst_n     (reset),
        .hold      (act == ACT_HOLD),
        .bubble    ((act != ACT_SHIFT) | ~id_valid),
        .d_valid   (id_valid),
        .d_ctrl    (id_ctrl),
        .d_rd      (id_rd),
        .d_is_load (id_is_load),
        .d_rd_we   (id_rd_we),
        .q_valid   (v[k]),
        .q_ctrl    (c[k]),
        .q_rd      (r[k]),
        .q_is_load (ld[k]),
        .q_rd_we   (we[k])
      );
    end else begin : g_next
      pipe_stage_reg #(.CTRL_W(CTRL_W), .REG_W(REG_W)) u_reg (
        .clk       (clk),
        .rst_n     (reset),
        .hold      (act == ACT_HOLD),
        .bubble    (1'b0),
        .d_valid   (v[k-1]),
        .d_ctrl    (c[k-1]),
        .d_rd      (r[k-1]),
        .d_is_load (ld[k-1]),
        .d_rd_we   (we[k-1]),
        .q_valid   (v[k]),
        .q_ctrl    (c[k]),
        .q_rd      (r[k]),
        .q_is_load (ld[k]),
        .q_rd_we   (we[k])
      );
    end
  end

  // Pack stage outputs; invalid stages always show a zero bundle
  always_comb begin
    stage_valid = v;
    stage_ctrl  = '0;
    stage_rd    = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      stage_ctrl[k*CTRL_W +: CTRL_W] = v[k] ? c[k] : '0;
      stage_rd[k*REG_W +: REG_W]     = r[k];
    end
  end

  // Load/write flags beyond EX are carried for completeness but not consumed here
  assign unused_tail = ^{ld, we};

  // Saturating stall/flush counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (act == ACT_FLUSH && flush_cnt != '1)  flush_cnt <= flush_cnt + 1'b1;
      if (act == ACT_HAZARD && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain: a 3-stage and a 5-stage instance share stimulus.
module tb_ctrl_pipe_chain;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_is_load, id_rd_we, id_rs_a_use, id_rs_b_use;
  logic [15:0] id_ctrl;
  logic [3:0]  id_rd, id_rs_a, id_rs_b;
  logic        flush, ext_stall;

  logic        pc_le3, ifid_le3, ifid_clr3, hazard3;
  logic [2:0]  sv3;
  logic [47:0] sc3;
  logic [11:0] sr3;
  logic [15:0] stall3, flushc3;

  logic        pc_le5, ifid_le5, ifid_clr5, hazard5;
  logic [4:0]  sv5;
  logic [79:0] sc5;
  logic [19:0] sr5;
  logic [15:0] stall5, flushc5;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [15:0] A1 = 16'h0101, A2 = 16'h0202, A3 = 16'h0303, A4 = 16'h0404;
  localparam logic [15:0] LD = 16'h1080, ADD = 16'h0011, OTH = 16'h0022;

  always #5 clk = ~clk;

  ctrl_pipe_chain #(.CTRL_W(16), .STAGES(3), .REG_W(4), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_is_load(id_is_load), .id_rd_we(id_rd_we), .id_rd(id_rd),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_rs_a_use(id_rs_a_use), .id_rs_b_use(id_rs_b_use),
    .flush(flush), .ext_stall(ext_stall), .pc_le(pc_le3), .ifid_le(ifid_le3),
    .ifid_clr(ifid_clr3), .hazard(hazard3), .stage_valid(sv3), .stage_ctrl(sc3),
    .stage_rd(sr3), .stall_cnt(stall3), .flush_cnt(flushc3)
  );

  ctrl_pipe_chain #(.CTRL_W(16), .STAGES(5), .REG_W(4), .CNT_W(16)) dut5 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_is_load(id_is_load), .id_rd_we(id_rd_we), .id_rd(id_rd),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_rs_a_use(id_rs_a_use), .id_rs_b_use(id_rs_b_use),
    .flush(flush), .ext_stall(ext_stall), .pc_le(pc_le5), .ifid_le(ifid_le5),
    .ifid_clr(ifid_clr5), .hazard(hazard5), .stage_valid(sv5), .stage_ctrl(sc5),
    .stage_rd(sr5), .stall_cnt(stall5), .flush_cnt(flushc5)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [15:0] c, input logic [3:0] rd,
                        input logic is_ld, input logic we,
                        input logic [3:0] ra, input logic ua, input logic [3:0] rb, input logic ub);
    id_valid = v; id_ctrl = c; id_rd = rd; id_is_load = is_ld; id_rd_we = we;
    id_rs_a = ra; id_rs_a_use = ua; id_rs_b = rb; id_rs_b_use = ub;
  endtask

  task automatic idle();
    set_id(1'b0, 16'h0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    idle();
    #12;
    // reset state
    chk("rst_valid", 80'(sv3), 80'h0);
    chk("rst_ctrl", 80'(sc3), 80'h0);
    chk("rst_stall_cnt", 80'(stall3), 80'h0);
    chk("rst_flush_cnt", 80'(flushc3), 80'h0);
    chk("rst_pc_le", 80'(pc_le3), 80'h1);
    chk("rst_ifid_le", 80'(ifid_le3), 80'h1);
    chk("rst_ifid_clr", 80'(ifid_clr3), 80'h0);
    reset = 1'b1;

    // four ALU ops back to back
    set_id(1'b1, A1, 4'd1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    chk("s1_e1_s0", 80'(sc3[15:0]), 80'(A1));
    chk("s1_e1_valid", 80'(sv3), 80'h1);
    chk("s1_e1_s0_5", 80'(sc5[15:0]), 80'(A1));
    set_id(1'b1, A2, 4'd2, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    chk("s1_e2_s1", 80'(sc3[31:16]), 80'(A1));
    chk("s1_e2_s0", 80'(sc3[15:0]), 80'(A2));
    set_id(1'b1, A3, 4'd3, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    chk("s1_e3_s2", 80'(sc3[47:32]), 80'(A1));
    chk("s1_e3_valid", 80'(sv3), 80'h7);
    chk("s1_e3_rd", 80'(sr3), 80'h123);
    set_id(1'b1, A4, 4'd4, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    chk("s1_e4_s2", 80'(sc3[47:32]), 80'(A2));
    chk("s1_e4_s3_5", 80'(sc5[63:48]), 80'(A1));
    idle();
    tick();
    chk("s1_e5_s4_5", 80'(sc5[79:64]), 80'(A1));
    chk("s1_e5_valid", 80'(sv3), 80'h6);
    chk("s1_e5_s0_zero", 80'(sc3[15:0]), 80'h0);
    chk("s1_e5_valid_5", 80'(sv5), 80'h1e);
    repeat (3) tick();
    chk("s1_drained", 80'(sv3), 80'h0);

    // load r3 then ADD reading r3
    set_id(1'b1, LD, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    set_id(1'b1, ADD, 4'd5, 1'b0, 1'b1, 4'd3, 1'b1, 4'd9, 1'b1);
    #1;
    chk("s2_hazard", 80'(hazard3), 80'h1);
    chk("s2_pc_le", 80'(pc_le3), 80'h0);
    chk("s2_ifid_le", 80'(ifid_le3), 80'h0);
    chk("s2_ifid_clr", 80'(ifid_clr3), 80'h0);
    tick();
    chk("s2_bubble_v", 80'(sv3), 80'h2);
    chk("s2_bubble_c", 80'(sc3[15:0]), 80'h0);
    chk("s2_load_s1", 80'(sc3[31:16]), 80'(LD));
    chk("s2_stall_cnt", 80'(stall3), 80'h1);
    chk("s2_hazard_gone", 80'(hazard3), 80'h0);
    chk("s2_pc_le_back", 80'(pc_le3), 80'h1);
    tick();
    chk("s2_add_s0", 80'(sc3[15:0]), 80'(ADD));
    chk("s2_add_rd", 80'(sr3[3:0]), 80'h5);
    chk("s2_stall_hold", 80'(stall3), 80'h1);

    // load r3 then consumer with the r3 port unused
    idle();
    repeat (3) tick();
    set_id(1'b1, LD, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    set_id(1'b1, OTH, 4'd6, 1'b0, 1'b1, 4'd3, 1'b0, 4'd7, 1'b1);
    #1;
    chk("s3_no_hazard", 80'(hazard3), 80'h0);
    chk("s3_pc_le", 80'(pc_le3), 80'h1);
    tick();
    chk("s3_s0", 80'(sc3[15:0]), 80'(OTH));
    chk("s3_stall_cnt", 80'(stall3), 80'h1);

    // flush together with hazard
    set_id(1'b1, LD, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    set_id(1'b1, ADD, 4'd5, 1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0);
    flush = 1'b1;
    #1;
    chk("s4_hazard", 80'(hazard3), 80'h1);
    chk("s4_ifid_clr", 80'(ifid_clr3), 80'h1);
    chk("s4_pc_le", 80'(pc_le3), 80'h1);
    chk("s4_ifid_le", 80'(ifid_le3), 80'h1);
    tick();
    flush = 1'b0;
    idle();
    chk("s4_bubble", 80'({sv3[0], sc3[15:0]}), 80'h0);
    chk("s4_flush_cnt", 80'(flushc3), 80'h1);
    chk("s4_stall_cnt", 80'(stall3), 80'h1);

    // ext_stall for three cycles with a flush pending
    repeat (3) tick();
    set_id(1'b1, A1, 4'd1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    set_id(1'b1, A2, 4'd2, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    set_id(1'b1, A3, 4'd3, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    set_id(1'b1, A4, 4'd4, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    ext_stall = 1'b1;
    flush = 1'b1;
    #1;
    chk("s5_pc_le", 80'(pc_le3), 80'h0);
    chk("s5_ifid_le", 80'(ifid_le3), 80'h0);
    chk("s5_ifid_clr", 80'(ifid_clr3), 80'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("s5_frozen_%0d", i), 80'(sc3), 80'({A1, A2, A3}));
      chk($sformatf("s5_flush_ign_%0d", i), 80'(flushc3), 80'h1);
    end
    chk("s5_stall_cnt", 80'(stall3), 80'h1);
    ext_stall = 1'b0;
    flush = 1'b0;
    tick();
    chk("s5_resume1", 80'(sc3), 80'({A2, A3, A4}));
    idle();
    tick();
    chk("s5_resume2", 80'(sc3), 80'({A3, A4, 16'h0}));
    chk("s5_resume2_v", 80'(sv3), 80'h6);

    // asynchronous reset mid-flight
    set_id(1'b1, A1, 4'd1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    set_id(1'b1, A2, 4'd2, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    set_id(1'b1, A3, 4'd3, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
    chk("s6_full", 80'(sv3), 80'h7);
    #3;
    reset = 1'b0;
    #1;
    chk("s6_valid", 80'(sv3), 80'h0);
    chk("s6_ctrl", 80'(sc3), 80'h0);
    chk("s6_stall_cnt", 80'(stall3), 80'h0);
    chk("s6_flush_cnt", 80'(flushc3), 80'h0);
    chk("s6_valid_5", 80'(sv5), 80'h0);
    chk("s6_pc_le", 80'(pc_le3), 80'h1);
    reset = 1'b1;
    set_id(1'b1, A1, 4'd1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    chk("s6_restart_v", 80'(sv3), 80'h1);
    chk("s6_restart_c", 80'(sc3), 80'(A1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
